dmem_arbiter: RTL
=================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter DATA_BASE, 32'h10010000, byte address of DMEM word 0.
REQ-002 Parameter DEPTH_BITS, 11, DMEM word-index width (2048 words).
REQ-003 clk_in  input  1  single system clock, rising-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 cpu_req, cpu_we  input  1 each  CPU data-port request; write when cpu_we=1.
REQ-006 cpu_addr, cpu_wdata  input  32 each  CPU byte address (MARS data segment) and write data.
REQ-007 cpu_rdata  output  32  registered read data; cpu_ack  output  1  one-cycle completion pulse; cpu_err  output  1  error flag, valid with cpu_ack.
REQ-008 dbg_req, dbg_we, dbg_addr, dbg_wdata, dbg_rdata, dbg_ack, dbg_err: debug/loader port, identical widths and meaning to cpu_*.
REQ-009 mem_ena  output  1  DMEM write enable; mem_addr  output  DEPTH_BITS  word index; mem_wdata  output  32; mem_rdata  input  32  combinational DMEM read data.

Function
REQ-010 FSM states IDLE, SERVE, ACK; one access completes every 3 cycles.
REQ-011 IDLE: at the rising edge with any req high, grant one requester, latch its we/addr/wdata, go to SERVE; no req -> stay IDLE.
REQ-012 Simultaneous cpu_req and dbg_req: grant the requester not granted last (round-robin); last_grant resets to DBG so CPU wins first tie.
REQ-013 SERVE: drive mem_addr = (latched addr - DATA_BASE) >> 2, truncated to DEPTH_BITS; mem_wdata = latched wdata; mem_ena = latched we AND no error.
REQ-014 End of SERVE: latch mem_rdata into granted port's rdata (0 on error or write), go to ACK.
REQ-015 ACK: granted port's ack=1 for exactly this cycle, err valid; requests ignored; next state IDLE.
REQ-016 Error when addr < DATA_BASE, (addr - DATA_BASE) >> 2 >= 2**DEPTH_BITS, or addr[1:0] != 0; erroneous write never asserts mem_ena.
REQ-017 Requester changes to addr/wdata/we during SERVE or ACK do not affect the access in flight.
REQ-018 Non-granted port: ack=0, err=0, rdata holds previous value.
REQ-019 mem_ena=0 in IDLE and ACK; mem_addr/mem_wdata are don't-care outside SERVE but driven from latched registers (no X).
REQ-020 A requester holding req through ACK is re-sampled in the following IDLE and serviced again (round-robin still applies).

Reset
REQ-021 Reset asserted: state=IDLE, all ack/err=0, all rdata=0, mem_ena=0, latched request registers=0, last_grant=DBG, immediately (asynchronous).
REQ-022 Reset during SERVE: the in-flight write is aborted (mem_ena falls with reset), no ack is issued after release.
REQ-023 First request is sampled at the first rising edge after reset deasserts.

Structure
REQ-024 Shared package holds DATA_BASE, DEPTH_BITS, state encoding (IDLE/SERVE/ACK) and grant encoding (CPU/DBG).
REQ-025 One sub-module dmem_addr_xlate: combinational byte-address to word-index translation plus range/alignment error, instantiated once on the latched address.

Verification
REQ-026 Single write: cpu write addr 32'h10010008 data 32'hDEADBEEF -> mem_ena=1, mem_addr=2 in SERVE; cpu_ack 2 cycles after sampling edge, cpu_err=0.
REQ-027 Read-back: cpu read 32'h10010008 -> cpu_rdata=32'hDEADBEEF with cpu_ack, mem_ena never 1.
REQ-028 Contention: cpu_req and dbg_req held high from reset release -> grants CPU, DBG, CPU, DBG; acks alternate every 3 cycles.
REQ-029 Errors: dbg write 32'h1000FFFC, 32'h10012000 and 32'h10010002 -> dbg_err=1 with dbg_ack each time, mem_ena stays 0.
REQ-030 Reset mid-SERVE: assert reset during SERVE of a cpu write to 32'h10010010 -> mem_ena drops same cycle, no cpu_ack, subsequent read of that address returns old value.
REQ-031 Boundary: cpu write 32'h10011FFC -> mem_addr=2047, no error.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// Shared definitions for the data-memory arbiter: memory map defaults,
// FSM state encoding and requester (grant) encoding.
package dmem_arbiter_pkg;

  localparam logic [31:0] DMEM_DATA_BASE  = 32'h1001_0000;
  localparam int          DMEM_DEPTH_BITS = 11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SERVE = 2'd1,
    ST_ACK   = 2'd2
  } state_t;

  typedef enum logic {
    GNT_CPU = 1'b0,
    GNT_DBG = 1'b1
  } grant_t;

endpackage

// File: rtl/dmem_addr_xlate.sv
// Byte address to DMEM word index translation with range and alignment check.
module dmem_addr_xlate
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DMEM_DATA_BASE,
  parameter int          DEPTH_BITS = DMEM_DEPTH_BITS
) (
  input  logic [31:0]           addr,
  output logic [DEPTH_BITS-1:0] word_idx,
  output logic                  err
);

  // DATA_BASE is word aligned, so comparing word addresses is exact.
  localparam logic [29:0] BASE_WORD = DATA_BASE[31:2];

  logic [29:0] off;
  logic        below;
  logic        over;
  logic        misaligned;

  always_comb begin
    off        = addr[31:2] - BASE_WORD;
    below      = addr[31:2] < BASE_WORD;
    over       = |off[29:DEPTH_BITS];
    misaligned = |addr[1:0];
    word_idx   = off[DEPTH_BITS-1:0];
    err        = below | over | misaligned;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-port DMEM between the CPU data port
// and a debug/loader port; each access takes IDLE -> SERVE -> ACK.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter logic [31:0] DATA_BASE  = DMEM_DATA_BASE,
  parameter int          DEPTH_BITS = DMEM_DEPTH_BITS
) (
  input  logic                  clk_in,
  input  logic                  reset,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic [31:0]           cpu_addr,
  input  logic [31:0]           cpu_wdata,
  output logic [31:0]           cpu_rdata,
  output logic                  cpu_ack,
  output logic                  cpu_err,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [31:0]           dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic [31:0]           dbg_rdata,
  output logic                  dbg_ack,
  output logic                  dbg_err,
  output logic                  mem_ena,
  output logic [DEPTH_BITS-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  input  logic [31:0]           mem_rdata
);

  state_t                state_q, state_d;
  grant_t                grant_q, pick;
  logic                  take;
  logic                  we_q;
  logic [31:0]           addr_q;
  logic [31:0]           wdata_q;
  logic                  err_q;
  logic                  xerr;
  logic [DEPTH_BITS-1:0] word_idx;
  logic [31:0]           serve_rdata;

  dmem_addr_xlate #(
    .DATA_BASE  (DATA_BASE),
    .DEPTH_BITS (DEPTH_BITS)
  ) u_xlate (
    .addr     (addr_q),
    .word_idx (word_idx),
    .err      (xerr)
  );

  // grant_q doubles as the round-robin "last granted" memory.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      grant_q <= GNT_DBG;
    end else begin
      state_q <= state_d;
      if (take) grant_q <= pick;
    end
  end

  always_comb begin
    state_d = state_q;
    take    = 1'b0;
    pick    = GNT_CPU;
    case (state_q)
      ST_IDLE: begin
        if (cpu_req || dbg_req) begin
          take    = 1'b1;
          state_d = ST_SERVE;
          if (cpu_req && dbg_req) pick = (grant_q == GNT_CPU) ? GNT_DBG : GNT_CPU;
          else if (cpu_req)       pick = GNT_CPU;
          else                    pick = GNT_DBG;
        end
      end
      ST_SERVE: state_d = ST_ACK;
      ST_ACK:   state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_ena     = (state_q == ST_SERVE) && we_q && !xerr;
    mem_addr    = word_idx;
    mem_wdata   = wdata_q;
    serve_rdata = (xerr || we_q) ? 32'd0 : mem_rdata;
    cpu_ack     = (state_q == ST_ACK) && (grant_q == GNT_CPU);
    dbg_ack     = (state_q == ST_ACK) && (grant_q == GNT_DBG);
    cpu_err     = cpu_ack && err_q;
    dbg_err     = dbg_ack && err_q;
  end

  // Request capture at grant; read data capture at the end of SERVE.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      we_q      <= 1'b0;
      addr_q    <= 32'd0;
      wdata_q   <= 32'd0;
      err_q     <= 1'b0;
      cpu_rdata <= 32'd0;
      dbg_rdata <= 32'd0;
    end else begin
      if (take) begin
        we_q    <= (pick == GNT_CPU) ? cpu_we    : dbg_we;
        addr_q  <= (pick == GNT_CPU) ? cpu_addr  : dbg_addr;
        wdata_q <= (pick == GNT_CPU) ? cpu_wdata : dbg_wdata;
      end
      if (state_q == ST_SERVE) begin
        err_q <= xerr;
        if (grant_q == GNT_CPU) cpu_rdata <= serve_rdata;
        else                    dbg_rdata <= serve_rdata;
      end
    end
  end

endmodule
